// File: rtl/external_memory_bridge.sv
// Bridges a delay line's per-tick write/read intent onto a req/ack external memory port:
// optional write, then one read. Define EXT_MEM_BRIDGE_TIMEOUT_EN to enable the ack watchdog.
module external_memory_bridge #(
    parameter int                    DWIDTH     = 16,
    parameter int                    AWIDTH     = 16,
    parameter int                    MEM_AWIDTH = 24,
    parameter logic [MEM_AWIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  sample_tick_i,
    input  logic                  write_enable_i,
    input  logic [AWIDTH-1:0]     write_address_i,
    input  logic [DWIDTH-1:0]     writedata_i,
    input  logic [AWIDTH-1:0]     read_address_i,
    output logic [DWIDTH-1:0]     readdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [MEM_AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0]     mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DWIDTH-1:0]     mem_rdata_i,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [AWIDTH-1:0]     waddr_q, waddr_next;
    logic [AWIDTH-1:0]     raddr_q, raddr_next;
    logic [DWIDTH-1:0]     wdata_q, wdata_next;
    logic [MEM_AWIDTH-1:0] addr_next;
    logic [DWIDTH-1:0]     rdata_next;
    logic                  accept;
    logic                  xfer_done;
    logic                  wd_expire;
    logic                  set_timeout;
    logic                  set_overrun;
    logic                  load_rdata;

    function automatic logic [MEM_AWIDTH-1:0] to_mem_addr(input logic [AWIDTH-1:0] addr);
        return BASE_ADDR + MEM_AWIDTH'(addr);
    endfunction

    assign xfer_done   = mem_req_o && mem_ack_i;
    assign set_overrun = sample_tick_i && (state != IDLE);
    assign busy_o      = (state != IDLE);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        state_next  = state;
        accept      = 1'b0;
        set_timeout = 1'b0;
        load_rdata  = 1'b0;
        rdata_next  = mem_rdata_i;
        case (state)
            IDLE: begin
                if (sample_tick_i) begin
                    accept     = 1'b1;
                    state_next = write_enable_i ? WRITE : READ;
                end
            end
            WRITE: begin
                // An abandoned write still falls through to the read.
                if (xfer_done) begin
                    state_next = READ;
                end else if (wd_expire) begin
                    state_next  = READ;
                    set_timeout = 1'b1;
                end
            end
            READ: begin
                if (xfer_done) begin
                    load_rdata = 1'b1;
                    state_next = IDLE;
                end else if (wd_expire) begin
                    load_rdata  = 1'b1;
                    rdata_next  = '0;
                    set_timeout = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latches only move on an accepted tick, which keeps address/data stable per request.
    assign waddr_next = accept ? write_address_i : waddr_q;
    assign raddr_next = accept ? read_address_i  : raddr_q;
    assign wdata_next = accept ? writedata_i     : wdata_q;
    assign addr_next  = (state_next == WRITE) ? to_mem_addr(waddr_next) : to_mem_addr(raddr_next);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n_i) begin
            state       <= IDLE;
            waddr_q     <= '0;
            raddr_q     <= '0;
            wdata_q     <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            readdata_o  <= '0;
            overrun_o   <= 1'b0;
        end else begin
            state       <= state_next;
            waddr_q     <= waddr_next;
            raddr_q     <= raddr_next;
            wdata_q     <= wdata_next;
            // Memory-side outputs are registered from the next state.
            mem_req_o   <= (state_next != IDLE);
            mem_we_o    <= (state_next == WRITE);
            mem_addr_o  <= addr_next;
            mem_wdata_o <= wdata_next;
            if (load_rdata) begin
                readdata_o <= rdata_next;
            end
            if (set_overrun) begin
                overrun_o <= 1'b1;
            end
        end
    end

`ifdef EXT_MEM_BRIDGE_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] wd_cnt;

    assign wd_expire = (state != IDLE) && !xfer_done && (wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            // Restart on every entry into WRITE or READ.
            if ((state_next != state) || (state == IDLE)) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + CW'(1);
            end
            if (set_timeout) begin
                timeout_o <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign wd_expire      = 1'b0;
    assign timeout_o      = 1'b0;
    assign unused_timeout = set_timeout ^ (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_external_memory_bridge.sv
// Self-checking bench for external_memory_bridge: random ticks against a transaction-level
// reference model, plus directed latency, overrun, reset and watchdog scenarios.
module tb_external_memory_bridge;

    localparam int             DW   = 16;
    localparam int             AW   = 16;
    localparam int             MAW  = 24;
    localparam int             TO   = 8;
    localparam logic [MAW-1:0] BASE = 24'h000100;

    logic           clk_i = 1'b0;
    logic           rst_n_i = 1'b0;
    logic           sample_tick_i = 1'b0;
    logic           write_enable_i = 1'b0;
    logic [AW-1:0]  write_address_i = '0;
    logic [DW-1:0]  writedata_i = '0;
    logic [AW-1:0]  read_address_i = '0;
    logic [DW-1:0]  readdata_o;
    logic           mem_req_o;
    logic           mem_we_o;
    logic [MAW-1:0] mem_addr_o;
    logic [DW-1:0]  mem_wdata_o;
    logic           mem_ack_i;
    logic [DW-1:0]  mem_rdata_i;
    logic           busy_o;
    logic           overrun_o;
    logic           timeout_o;

    external_memory_bridge #(
        .DWIDTH    (DW),
        .AWIDTH    (AW),
        .MEM_AWIDTH(MAW),
        .BASE_ADDR (BASE),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .sample_tick_i  (sample_tick_i),
        .write_enable_i (write_enable_i),
        .write_address_i(write_address_i),
        .writedata_i    (writedata_i),
        .read_address_i (read_address_i),
        .readdata_o     (readdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_ack_i      (mem_ack_i),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // External memory responder with per-direction programmable ack wait.
    typedef struct {
        logic           we;
        logic [MAW-1:0] addr;
        logic [DW-1:0]  data;
        int             edge_no;
    } xfer_t;

    logic [DW-1:0]  mem [0:131071];
    xfer_t          log_q [$];
    int             wr_wait = 0;
    int             rd_wait = 0;
    int             wait_cnt = 0;
    int             edge_cnt = 0;
    int             unstable = 0;
    logic           in_req = 1'b0;
    logic           hold_we = 1'b0;
    logic [MAW-1:0] hold_addr = '0;
    logic [DW-1:0]  hold_wdata = '0;

    assign mem_ack_i   = mem_req_o && (wait_cnt >= (mem_we_o ? wr_wait : rd_wait));
    assign mem_rdata_i = mem[mem_addr_o[16:0]];

    always @(posedge clk_i) begin
        edge_cnt++;
        if (mem_req_o) begin
            if (!in_req || (mem_we_o !== hold_we)) begin
                in_req     = 1'b1;
                hold_we    = mem_we_o;
                hold_addr  = mem_addr_o;
                hold_wdata = mem_wdata_o;
            end else if ((mem_addr_o !== hold_addr) || (mem_we_o && (mem_wdata_o !== hold_wdata))) begin
                unstable++;
            end
            if (mem_ack_i) begin
                log_q.push_back('{mem_we_o, mem_addr_o, (mem_we_o ? mem_wdata_o : mem_rdata_i), edge_cnt});
                if (mem_we_o) mem[mem_addr_o[16:0]] <= mem_wdata_o;
                in_req = 1'b0;
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            in_req = 1'b0;
            wait_cnt <= 0;
        end
    end

    // Reference model: delay-line view of memory and the word the delay line should see.
    logic [DW-1:0] ref_mem [0:65535];
    logic [DW-1:0] ref_rd = '0;

    task automatic scramble_inputs();
        write_enable_i  = 1'($urandom);
        write_address_i = AW'($urandom);
        writedata_i     = DW'($urandom);
        read_address_i  = AW'($urandom);
    endtask

    // One accepted tick; extra_at > 0 fires a second tick that many edges after the first.
    task automatic run_tick(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input logic [AW-1:0] ra, input int ww, input int rw, input int extra_at);
        int            t, e_w, e_r, idx;
        logic [DW-1:0] exp_rd;
        wr_wait = ww;
        rd_wait = rw;
        log_q.delete();
        unstable = 0;
        @(negedge clk_i);
        write_enable_i  = we;
        write_address_i = wa;
        writedata_i     = wd;
        read_address_i  = ra;
        sample_tick_i   = 1'b1;
        t = edge_cnt + 1;
        if (we) ref_mem[wa] = wd;
        exp_rd = ref_mem[ra];
        e_w = t + 1 + ww;
        e_r = we ? (e_w + 1 + rw) : (t + 1 + rw);
        @(negedge clk_i);
        sample_tick_i = 1'b0;
        scramble_inputs();
        while (edge_cnt < e_r) begin
            if (edge_cnt == e_r - 1) begin
                check("busy_before_done", busy_o, 1'b1);
                check("rdata_held", readdata_o, ref_rd);
            end
            sample_tick_i = (extra_at > 0) && (edge_cnt == t + extra_at - 1);
            @(negedge clk_i);
        end
        sample_tick_i = 1'b0;
        check("rdata_updated", readdata_o, exp_rd);
        check("busy_done", busy_o, 1'b0);
        check("req_done", mem_req_o, 1'b0);
        check("xfer_count", log_q.size(), we ? 2 : 1);
        idx = 0;
        if (we) begin
            if (log_q.size() > 0) begin
                check("wr_we", log_q[0].we, 1'b1);
                check("wr_addr", log_q[0].addr, BASE + MAW'(wa));
                check("wr_data", log_q[0].data, wd);
                check("wr_edge", log_q[0].edge_no, e_w);
            end
            idx = 1;
        end
        if (log_q.size() > idx) begin
            check("rd_we", log_q[idx].we, 1'b0);
            check("rd_addr", log_q[idx].addr, BASE + MAW'(ra));
            check("rd_data", log_q[idx].data, exp_rd);
            check("rd_edge", log_q[idx].edge_no, e_r);
        end
        check("req_stable", unstable, 0);
        ref_rd = exp_rd;
    endtask

    int            t0;
    logic [AW-1:0] rst_wa;
    logic [DW-1:0] rst_wd;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i] = DW'($urandom);
            mem[int'(BASE) + i] = ref_mem[i];
        end
        ref_mem[16'h000F] = 16'hBEEF;
        mem[int'(BASE) + 16'h000F] = 16'hBEEF;

        repeat (3) @(negedge clk_i);
        check("rst_req", mem_req_o, 1'b0);
        check("rst_we", mem_we_o, 1'b0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_rdata", readdata_o, 0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_overrun", overrun_o, 1'b0);
        check("rst_timeout", timeout_o, 1'b0);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Zero-wait write+read, then read-only, then 4-cycle ack delays.
        run_tick(1'b1, 16'h0010, 16'h1234, 16'h000F, 0, 0, 0);
        run_tick(1'b0, 16'h0022, 16'h5555, 16'h0010, 0, 0, 0);
        run_tick(1'b1, 16'h0030, 16'hA5C3, 16'h0031, 4, 4, 0);
        run_tick(1'b1, 16'hFFFF, 16'h0F0F, 16'hFFFF, 1, 2, 0);

        for (int n = 0; n < 20; n++) begin
            run_tick(1'($urandom), AW'($urandom_range(0, 31)), DW'($urandom),
                     AW'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end
        check("overrun_clear_before", overrun_o, 1'b0);

        // Second tick lands on the read's ack cycle.
        run_tick(1'b1, 16'h0040, 16'h7777, 16'h0041, 0, 0, 2);
        repeat (4) @(negedge clk_i);
        check("overrun_set", overrun_o, 1'b1);
        check("overrun_no_extra_xfer", log_q.size(), 2);
        check("overrun_rdata_kept", readdata_o, ref_rd);

        // Reset pulse while the read is pending.
        rst_wa = 16'h0050;
        rst_wd = 16'h9ABC;
        wr_wait = 0;
        rd_wait = 20;
        log_q.delete();
        @(negedge clk_i);
        write_enable_i  = 1'b1;
        write_address_i = rst_wa;
        writedata_i     = rst_wd;
        read_address_i  = 16'h0051;
        sample_tick_i   = 1'b1;
        @(negedge clk_i);
        sample_tick_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_in_read_req", mem_req_o, 1'b1);
        check("rst_mid_in_read_we", mem_we_o, 1'b0);
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_mid_req", mem_req_o, 1'b0);
        check("rst_mid_busy", busy_o, 1'b0);
        check("rst_mid_overrun", overrun_o, 1'b0);
        check("rst_mid_timeout", timeout_o, 1'b0);
        check("rst_mid_rdata", readdata_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        ref_mem[rst_wa] = rst_wd;
        ref_rd = '0;
        run_tick(1'b0, 16'h0000, 16'h0000, rst_wa, 0, 1, 0);
        check("post_rst_overrun", overrun_o, 1'b0);

`ifdef EXT_MEM_BRIDGE_TIMEOUT_EN
        // Ack never comes: each phase must give up after TIMEOUT cycles.
        wr_wait = 1000;
        rd_wait = 1000;
        log_q.delete();
        @(negedge clk_i);
        write_enable_i  = 1'b1;
        write_address_i = 16'h0060;
        writedata_i     = 16'h1111;
        read_address_i  = 16'h0061;
        sample_tick_i   = 1'b1;
        t0 = edge_cnt + 1;
        @(negedge clk_i);
        sample_tick_i = 1'b0;
        while (edge_cnt < t0 + 2 * TO) begin
            if (edge_cnt == t0 + TO - 1) begin
                check("to_still_write", mem_we_o, 1'b1);
                check("to_timeout_not_yet", timeout_o, 1'b0);
            end
            if (edge_cnt == t0 + TO) begin
                check("to_now_read_req", mem_req_o, 1'b1);
                check("to_now_read_we", mem_we_o, 1'b0);
            end
            if (edge_cnt == t0 + 2 * TO - 1) check("to_read_busy", busy_o, 1'b1);
            @(negedge clk_i);
        end
        check("to_busy", busy_o, 1'b0);
        check("to_req", mem_req_o, 1'b0);
        check("to_flag", timeout_o, 1'b1);
        check("to_rdata", readdata_o, 0);
        check("to_no_xfer", log_q.size(), 0);
`else
        t0 = 0;
        check("timeout_tied_low", timeout_o, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "global time limit reached");
    end

endmodule

// File: doc/external_memory_bridge.md
# external_memory_bridge

Sits directly downstream of a delay line's external-memory port. Each sample tick it converts that port's single-cycle write/read intent into a sequenced request/acknowledge transaction on a single-port external memory controller (SDRAM/SRAM front end): at most one write, then exactly one read. The fetched word is held on `readdata_o`, so the delay line sees valid data at its next sample tick.

## Interface
- `DWIDTH`, 16: sample width, bits.
- `AWIDTH`, 16: delay-line address width, bits.
- `MEM_AWIDTH`, 24: external memory address width; must be ≥ AWIDTH.
- `BASE_ADDR`, 0: offset added to every delay address, so several delay lines can share one memory.
- `TIMEOUT`, 255: ack watchdog limit in clock cycles. Used only with `EXT_MEM_BRIDGE_TIMEOUT_EN`.
- `clk_i` in 1: system clock.
- `rst_n_i` in 1: reset. One clock; reset is asynchronous and active-low.
- `sample_tick_i` in 1: one-cycle strobe marking the audio sample rate.
- `write_enable_i` in 1: delay line requests a write on this tick.
- `write_address_i` in AWIDTH: write address.
- `writedata_i` in DWIDTH: write data.
- `read_address_i` in AWIDTH: read address. A read is issued on every accepted tick.
- `readdata_o` out DWIDTH: last word read; stable between updates.
- `mem_req_o` out 1: memory request.
- `mem_we_o` out 1: 1 = write, 0 = read; valid while `mem_req_o` is high.
- `mem_addr_o` out MEM_AWIDTH: address, equal to `BASE_ADDR` + zero-extended delay address (modulo 2^MEM_AWIDTH).
- `mem_wdata_o` out DWIDTH: write data.
- `mem_ack_i` in 1: transfer completes in a cycle where `mem_req_o && mem_ack_i`. May be combinational from `mem_req_o`.
- `mem_rdata_i` in DWIDTH: read data, valid in the read's ack cycle.
- `busy_o` out 1: high in every state except IDLE.
- `overrun_o` out 1: sticky; set when a tick arrives while busy.
- `timeout_o` out 1: sticky watchdog flag.

## Operation
- FSM states: IDLE, WRITE, READ.
- IDLE + `sample_tick_i`:
  - latch write enable, write address, write data and read address;
  - go to WRITE if the latched write enable is 1, otherwise go to READ.
- WRITE: `mem_req_o`=1, `mem_we_o`=1, address and data from the write latch. On ack, go to READ.
- READ: `mem_req_o`=1, `mem_we_o`=0, address from the read latch. On ack, capture `mem_rdata_i` into `readdata_o` and go to IDLE.
- All memory-side outputs are registered. Address, data and `mem_we_o` are held constant for the whole request.
- Ticks are accepted only in IDLE.
  - A tick in WRITE or READ, including the final ack cycle, sets `overrun_o` and is otherwise ignored.
  - Ignored means: no latch update, and `readdata_o` keeps its value.
- Overrun and timeout flags clear only on reset.
- Reset asserted mid-transaction: asynchronously drop `mem_req_o` and return to IDLE. The pending transaction is abandoned.
- Reset values: all outputs 0, FSM in IDLE, latches 0.

## Timing
Tick sampled at cycle T. Zero-wait ack means ack in the first request cycle.
- With write, zero-wait:
  - T+1: write request.
  - T+2: read request.
  - T+3: `readdata_o` updated, `busy_o`=0.
- Without write, zero-wait:
  - T+1: read request.
  - T+2: `readdata_o` updated.
- Each wait cycle on an ack adds one cycle of latency.
- `mem_req_o` deasserts, or `mem_we_o` changes, in the cycle after ack. No back-to-back requests sit on the same registered value.
- Sample period must be ≥ 3 + total ack wait cycles. Otherwise overrun occurs.

## Configuration
- Macro `EXT_MEM_BRIDGE_TIMEOUT_EN`.
- Defined:
  - a cycle counter restarts on entry to WRITE or READ;
  - if `TIMEOUT` cycles pass without ack: abort the request, set `timeout_o`, load `readdata_o`=0, go to IDLE;
  - an aborted write still proceeds to the read.
- Undefined:
  - no counter;
  - waits indefinitely for ack;
  - `timeout_o` tied to 0.

## Test plan
- Zero-wait ack, tick with write_enable=1, waddr=0x0010, wdata=0x1234, raddr=0x000F, memory[0x000F]=0xBEEF, BASE_ADDR=0x100:
  - required: write to 0x110 at T+1, read of 0x10F at T+2, `readdata_o`=0xBEEF at T+3.
- Tick with write_enable=0:
  - required: only a read request is issued, and `readdata_o` updates at T+2.
- Ack delayed 4 cycles on each transfer:
  - required: request, address and data stay stable throughout, and `readdata_o` updates at T+11.
- Second tick at T+2 while busy:
  - required: `overrun_o`=1, `readdata_o` equals the first read's data, and no extra transfer occurs.
- `rst_n_i` pulsed low during READ:
  - required: `mem_req_o` and `busy_o` drop immediately, all flags clear, and the next tick runs normally.
- With `EXT_MEM_BRIDGE_TIMEOUT_EN`, TIMEOUT=8, ack never asserted:
  - required: abort after 8 cycles in WRITE and 8 cycles in READ, `timeout_o`=1, `readdata_o`=0, FSM back in IDLE.
